// File: rtl/l2_fwd_in_unpacker.sv
// ----------------------------------------------------------------------------
// l2_fwd_in_unpacker
//
// Reassembles a forward-plane NoC packet arriving at an L2 into one complete
// forward message (coh_msg, req_id, addr, sparse line, word_mask).
// Packet layout: HEAD (coh_msg, req_id, word_mask), address flit, then one
// data flit per set bit of word_mask in ascending word order. The final flit
// of the packet carries the TAIL preamble, every flit between HEAD and the
// final one carries BODY. The finished message is held in a one-entry output
// register until the L2 takes it. Framing violations drop the flit, discard
// the partial message and set a sticky proto_err.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   noc_valid/ready flit handshake; noc_data is {preamble, payload}
//   fwd_valid/ready message handshake to the L2 forward-input port
//   fwd_coh_msg     message type
//   fwd_req_id      requestor id
//   fwd_addr        line address
//   fwd_line        line data, word i at [i*WORD_W +: WORD_W], unmasked = 0
//   fwd_word_mask   valid words of fwd_line
//   proto_err       sticky framing error, cleared by err_clr
//   msg_cnt         delivered-message count (wraps)
// ----------------------------------------------------------------------------
module l2_fwd_in_unpacker #(
   parameter int NOC_W       = 66,
   parameter int MSG_W       = 5,
   parameter int CID_W       = 4,
   parameter int WORDS       = 4,
   parameter int WORD_W      = 64,
   parameter int LINE_ADDR_W = 27
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      noc_valid,
   output logic                      noc_ready,
   input  logic [NOC_W-1:0]          noc_data,
   output logic                      fwd_valid,
   input  logic                      fwd_ready,
   output logic [MSG_W-1:0]          fwd_coh_msg,
   output logic [CID_W-1:0]          fwd_req_id,
   output logic [LINE_ADDR_W-1:0]    fwd_addr,
   output logic [WORDS*WORD_W-1:0]   fwd_line,
   output logic [WORDS-1:0]          fwd_word_mask,
   output logic                      proto_err,
   input  logic                      err_clr,
   output logic [15:0]               msg_cnt
);

   localparam logic [1:0] PRE_HEAD = 2'b10;
   localparam logic [1:0] PRE_BODY = 2'b00;
   localparam logic [1:0] PRE_TAIL = 2'b01;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam logic [WORDS-1:0] ONE_W = WORDS'(1);

   localparam int COH_HI  = NOC_W - 3;
   localparam int RID_HI  = COH_HI - MSG_W;
   localparam int MASK_HI = RID_HI - CID_W;

   logic [1:0]             state;
   logic [MSG_W-1:0]       coh_msg_r;
   logic [CID_W-1:0]       req_id_r;
   logic [WORDS-1:0]       mask_r;
   logic [WORDS-1:0]       pending_r;
   logic [LINE_ADDR_W-1:0] addr_r;
   logic [WORDS*WORD_W-1:0] line_r;

   logic                   accept;
   logic [1:0]             pre;
   logic                   flit_err;
   logic [WORDS-1:0]       pending_rest;
   logic [WORDS-1:0]       pending_low;
   logic                   unused_bits;

   assign noc_ready = (state != S_OUT);
   assign fwd_valid = (state == S_OUT);
   assign accept    = noc_valid && noc_ready;
   assign pre       = noc_data[NOC_W-1 -: 2];

   // Pending mask with its lowest set bit removed, and that bit isolated.
   assign pending_rest = pending_r & (pending_r - ONE_W);
   assign pending_low  = pending_r & (~pending_r + ONE_W);

   // Payload bits beyond the decoded fields are intentionally ignored.
   assign unused_bits = ^noc_data;

   assign fwd_coh_msg   = coh_msg_r;
   assign fwd_req_id    = req_id_r;
   assign fwd_addr      = addr_r;
   assign fwd_line      = line_r;
   assign fwd_word_mask = mask_r;

   // Framing check: each state expects exactly one preamble. HEAD mid-message
   // and 2'b11 never match an expected code, so they fall out as errors too.
   always_comb begin
      flit_err = 1'b0;
      if (accept) begin
         case (state)
            S_IDLE:  flit_err = (pre != PRE_HEAD);
            S_HDR:   flit_err = (pre != ((mask_r == '0) ? PRE_TAIL : PRE_BODY));
            S_DATA:  flit_err = (pre != ((pending_rest == '0) ? PRE_TAIL : PRE_BODY));
            default: flit_err = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         coh_msg_r <= '0;
         req_id_r  <= '0;
         mask_r    <= '0;
         pending_r <= '0;
         addr_r    <= '0;
         line_r    <= '0;
         msg_cnt   <= '0;
      end else if (flit_err) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  coh_msg_r <= noc_data[COH_HI  -: MSG_W];
                  req_id_r  <= noc_data[RID_HI  -: CID_W];
                  mask_r    <= noc_data[MASK_HI -: WORDS];
                  line_r    <= '0;
                  state     <= S_HDR;
               end
            end
            S_HDR: begin
               if (accept) begin
                  addr_r    <= noc_data[LINE_ADDR_W-1:0];
                  pending_r <= mask_r;
                  state     <= (mask_r == '0) ? S_OUT : S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  for (int i = 0; i < WORDS; i++) begin
                     if (pending_low[i])
                        line_r[i*WORD_W +: WORD_W] <= noc_data[WORD_W-1:0];
                  end
                  pending_r <= pending_rest;
                  if (pending_rest == '0)
                     state <= S_OUT;
               end
            end
            default: begin
               if (fwd_ready) begin
                  state   <= S_IDLE;
                  msg_cnt <= msg_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // A new error in the same cycle as err_clr wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         proto_err <= 1'b0;
      else if (flit_err)
         proto_err <= 1'b1;
      else if (err_clr)
         proto_err <= 1'b0;
   end

endmodule
